// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter with a registered one-hot grant, optional burst
// ownership (MODE 1, up to MAX_HOLD acks per owner) and explicit pointer wrap.
module rr_grant_arbiter #(
    parameter int N_REQ    = 8,
    parameter int MODE     = 0,
    parameter int MAX_HOLD = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic                     ack,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     grant_valid
);

    localparam int             IW         = $clog2(N_REQ);
    localparam logic [IW-1:0]  LAST_IDX   = IW'(N_REQ - 1);
    localparam logic [7:0]     HOLD_LIMIT = 8'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t           state, state_d;
    logic [IW-1:0]    ptr, ptr_d;
    logic [7:0]       hold_cnt, hold_cnt_d;
    logic [N_REQ-1:0] grant_d;
    logic [IW-1:0]    grant_idx_d;
    logic             grant_valid_d;
    logic [IW-1:0]    base;
    logic             arbitrate;

    // First set request at or after base, scanning upward with wrap to 0.
    function automatic logic [IW-1:0] pick_first(input logic [N_REQ-1:0] r,
                                                 input logic [IW-1:0]    start);
        logic [IW-1:0] sel;
        int            idx;
        sel = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            idx = int'(start) + off;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (r[idx]) sel = idx[IW-1:0];
        end
        return sel;
    endfunction

    // Explicit compare rather than bit overflow so non-power-of-2 N_REQ wraps correctly.
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d       = state;
        ptr_d         = ptr;
        hold_cnt_d    = hold_cnt;
        grant_idx_d   = grant_idx;
        grant_valid_d = grant_valid;
        base          = ptr;
        arbitrate     = 1'b0;

        case (state)
            IDLE: arbitrate = 1'b1;
            OWN: begin
                // Abandonment outranks ack: the owner loses the grant either way.
                if (!req[grant_idx]) begin
                    arbitrate = 1'b1;
                end else if (ack) begin
                    if (MODE == 1 && hold_cnt < HOLD_LIMIT) begin
                        hold_cnt_d = hold_cnt + 8'd1;
                    end else begin
                        arbitrate = 1'b1;
                    end
                end
                if (arbitrate) begin
                    ptr_d = wrap_inc(grant_idx);
                    base  = ptr_d;
                end
            end
            default: arbitrate = 1'b1;
        endcase

        if (arbitrate) begin
            hold_cnt_d = '0;
            if (|req) begin
                state_d       = OWN;
                grant_idx_d   = pick_first(req, base);
                grant_valid_d = 1'b1;
            end else begin
                state_d       = IDLE;
                grant_idx_d   = '0;
                grant_valid_d = 1'b0;
            end
        end

        grant_d = '0;
        if (grant_valid_d) grant_d[grant_idx_d] = 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            hold_cnt    <= '0;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            hold_cnt    <= hold_cnt_d;
            grant       <= grant_d;
            grant_idx   <= grant_idx_d;
            grant_valid <= grant_valid_d;
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter: MODE 0 and MODE 1 with N_REQ=4, plus N_REQ=5 wrap.
module tb_rr_grant_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [3:0] req0 = '0, req1 = '0;
    logic [4:0] req2 = '0;
    logic       ack0 = 1'b0, ack1 = 1'b0, ack2 = 1'b0;
    logic [3:0] grant0, grant1;
    logic [4:0] grant2;
    logic [1:0] idx0, idx1;
    logic [2:0] idx2;
    logic       valid0, valid1, valid2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rr_grant_arbiter #(.N_REQ(4), .MODE(0), .MAX_HOLD(4)) u0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .ack(ack0),
        .grant(grant0), .grant_idx(idx0), .grant_valid(valid0));

    rr_grant_arbiter #(.N_REQ(4), .MODE(1), .MAX_HOLD(3)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .ack(ack1),
        .grant(grant1), .grant_idx(idx1), .grant_valid(valid1));

    rr_grant_arbiter #(.N_REQ(5), .MODE(0), .MAX_HOLD(4)) u2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .ack(ack2),
        .grant(grant2), .grant_idx(idx2), .grant_valid(valid2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst grant0", grant0, 4'b0000);
        check("rst idx0", idx0, 0);
        check("rst valid0", valid0, 0);
        check("rst valid1", valid1, 0);
        check("rst valid2", valid2, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // First grant from ptr=0
        req0 = 4'b1010; step();
        check("first grant", grant0, 4'b0010);
        check("first idx", idx0, 1);
        check("first valid", valid0, 1);

        // Owner holds without ack while others change
        req0 = 4'b1110; step();
        check("hold idx", idx0, 1);
        check("hold grant", grant0, 4'b0010);

        // Move to owner 3, then wrap to 0
        req0 = 4'b1000; ack0 = 1'b1; step();
        check("to idx3", idx0, 3);
        req0 = 4'b1001; step();
        check("wrap idx", idx0, 0);
        check("wrap ptr", u0.ptr, 0);

        // Owner 2 abandons with ack in the same cycle
        req0 = 4'b0100; step();
        check("to idx2", idx0, 2);
        req0 = 4'b0001; step();
        check("abandon idx", idx0, 0);
        check("abandon ptr", u0.ptr, 3);
        req0 = 4'b0100; step();
        check("to idx2 again", idx0, 2);
        req0 = 4'b0000; step();
        check("abandon idle valid", valid0, 0);
        check("abandon idle grant", grant0, 4'b0000);
        check("abandon idle idx", idx0, 0);

        // Ack while idle is ignored
        step();
        check("idle ack valid", valid0, 0);
        check("idle ack ptr", u0.ptr, 3);

        // Idle arbitration starts at ptr=3, wraps to 0
        ack0 = 1'b0; req0 = 4'b0011; step();
        check("idle from ptr3", idx0, 0);
        check("idle from ptr3 grant", grant0, 4'b0001);

        // Asynchronous reset mid-burst
        rst_n = 1'b0; #1;
        check("async rst grant", grant0, 4'b0000);
        check("async rst valid", valid0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("post rst ptr", u0.ptr, 0);

        // Rotation with ack every cycle, no idle cycle
        req0 = 4'b1111; step();
        check("rot idx 0", idx0, 0);
        ack0 = 1'b1;
        step(); check("rot idx 1", idx0, 1); check("rot valid 1", valid0, 1);
        step(); check("rot idx 2", idx0, 2); check("rot valid 2", valid0, 1);
        step(); check("rot idx 3", idx0, 3); check("rot valid 3", valid0, 1);
        step(); check("rot idx 0b", idx0, 0); check("rot grant 0b", grant0, 4'b0001);
        ack0 = 1'b0; req0 = '0;
        step();
        check("mode0 idle", valid0, 0);

        // MODE 1 burst, MAX_HOLD=3
        req1 = 4'b0011; step();
        check("burst g0", idx1, 0);
        ack1 = 1'b1;
        step(); check("burst a1", idx1, 0);
        step(); check("burst a2", idx1, 0);
        step(); check("burst a3", idx1, 1);
        step(); check("burst a4", idx1, 1);
        step(); check("burst a5", idx1, 1);
        step(); check("burst a6", idx1, 0);
        check("burst grant", grant1, 4'b0001);
        // Owner 0 abandons mid-burst
        ack1 = 1'b0; req1 = 4'b0010; step();
        check("burst abandon", idx1, 1);
        check("burst hold clr", u1.hold_cnt, 0);
        req1 = '0; step();
        check("burst idle", valid1, 0);

        // N_REQ=5 wrap from index 4
        req2 = 5'b10000; step();
        check("n5 idx4", idx2, 4);
        req2 = 5'b10001; ack2 = 1'b1; step();
        check("n5 wrap idx", idx2, 0);
        check("n5 wrap grant", grant2, 5'b00001);
        check("n5 wrap ptr", u2.ptr, 0);
        ack2 = 1'b0; req2 = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
